t05_ht_mem_ctrl: RTL and testbench



---
 rtl/t05_ht_pkg.sv | 39 +++
 rtl/t05_rr_arb2.sv | 26 ++
 rtl/t05_ht_mem_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_t05_ht_mem_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_ht_pkg.sv
// Shared types and constants for the Huffman tree-build SRAM access controller.
package t05_ht_pkg;

    localparam int NODE_W = 71;
    localparam int IDX_W  = 7;

    localparam logic [8:0] NULL_NODE  = 9'b110000000;
    localparam logic [3:0] HT_EN_TREE = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        WR1,
        WR2,
        RD0,
        RD1,
        RD2,
        DONE
    } state_t;

    // Byte address of word 'word' of node 'idx'; each node spans 3 words (12 bytes).
    function automatic logic [31:0] node_addr(input logic [31:0]      base,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [1:0]       word);
        return base + ({25'b0, idx} * 32'd12) + {28'b0, word, 2'b00};
    endfunction

    // Selects one of the three bus words of a node: index word, high data, low data.
    function automatic logic [31:0] node_word(input logic [IDX_W-1:0] idx,
                                              input logic [63:0]      data,
                                              input logic [1:0]       word);
        case (word)
            2'd0:    return {25'b0, idx};
            2'd1:    return data[63:32];
            default: return data[31:0];
        endcase
    endfunction

endpackage

// File: rtl/t05_rr_arb2.sv
// Two-way round-robin arbiter: on a conflict the side not granted last wins.
module t05_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b;

    assign gnt_a = en & req_a & (~req_b | last_b);
    assign gnt_b = en & req_b & (~req_a | ~last_b);

    // Remember which side won the most recent grant.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            last_b <= 1'b0;
        end else if (gnt_a | gnt_b) begin
            last_b <= gnt_b;
        end
    end

endmodule

// File: rtl/t05_ht_mem_ctrl.sv
// SRAM access controller for the tree-build stage: node writes, null-sum reads
// and codebook reads, each as a 3-beat single-word bus sequence.
import t05_ht_pkg::*;

module t05_ht_mem_ctrl #(
    parameter logic [31:0] NODE_BASE = 32'h3300_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        ht_en,
    input  logic              ht_pulse,
    input  logic [NODE_W-1:0] ht_node,
    input  logic              ht_rd,
    input  logic [IDX_W-1:0]  ht_rd_idx,
    input  logic              ht_fin,
    input  logic              cb_req,
    input  logic [IDX_W-1:0]  cb_idx,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              write_HT_fin,
    output logic              read_complete,
    output logic [63:0]       nulls,
    output logic              sram_complete,
    output logic              cb_ack,
    output logic [NODE_W-1:0] cb_node
);

    state_t             state, state_next;
    logic               ht_ok, ht_rd_q, rd_rise, rd_pend, rd_pend_next;
    logic               wr_req, rd_req, tree_req, arb_en, gnt_tree, gnt_cb;
    logic [IDX_W-1:0]   rd_idx_q, cap_idx;
    logic [63:0]        cap_data;
    logic               cap_cb;
    logic [IDX_W-1:0]   rd_w0;
    logic [31:0]        rd_w1;
    logic [1:0]         word_sel;
    logic               bus_req, bus_we;

    assign ht_ok    = (ht_en == HT_EN_TREE);
    // The tree builder holds WriteorRead for 1-2 cycles per request, so only its rising edge counts.
    assign rd_rise  = ht_rd & ~ht_rd_q;
    assign wr_req   = ht_ok & ht_pulse & ~write_HT_fin;
    assign rd_req   = ht_ok & (rd_pend | rd_rise);
    assign tree_req = wr_req | rd_req;
    assign arb_en   = (state == IDLE);

    t05_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req_a (tree_req),
        .req_b (cb_req),
        .gnt_a (gnt_tree),
        .gnt_b (gnt_cb)
    );

    // Pending tree read: cleared when a read wins, set on a new read edge otherwise.
    always_comb begin
        rd_pend_next = rd_pend;
        if (gnt_tree && !wr_req) begin
            rd_pend_next = 1'b0;
        end else if (ht_ok && rd_rise) begin
            rd_pend_next = 1'b1;
        end
    end

    // Next-state and bus-control decode; every beat holds until mem_ack.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        word_sel   = 2'd0;
        case (state)
            IDLE: begin
                if (gnt_tree) begin
                    state_next = wr_req ? WR0 : RD0;
                end else if (gnt_cb) begin
                    state_next = RD0;
                end
            end
            WR0: begin
                bus_req = 1'b1; bus_we = 1'b1; word_sel = 2'd0;
                if (mem_ack) state_next = WR1;
            end
            WR1: begin
                bus_req = 1'b1; bus_we = 1'b1; word_sel = 2'd1;
                if (mem_ack) state_next = WR2;
            end
            WR2: begin
                bus_req = 1'b1; bus_we = 1'b1; word_sel = 2'd2;
                if (mem_ack) state_next = DONE;
            end
            RD0: begin
                bus_req = 1'b1; word_sel = 2'd0;
                if (mem_ack) state_next = RD1;
            end
            RD1: begin
                bus_req = 1'b1; word_sel = 2'd1;
                if (mem_ack) state_next = RD2;
            end
            RD2: begin
                bus_req = 1'b1; word_sel = 2'd2;
                if (mem_ack) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are combinational from the state so an async reset drops them at once.
    assign mem_req   = bus_req;
    assign mem_we    = bus_we;
    assign mem_addr  = bus_req ? node_addr(NODE_BASE, cap_idx, word_sel) : 32'd0;
    assign mem_wdata = bus_we ? node_word(cap_idx, cap_data, word_sel) : 32'd0;

    // State register plus request tracking.
    always_ff @(posedge clk or posedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst_n) begin
            state         <= IDLE;
            ht_rd_q       <= 1'b0;
            rd_pend       <= 1'b0;
            rd_idx_q      <= '0;
            sram_complete <= 1'b0;
        end else begin
            state         <= state_next;
            ht_rd_q       <= ht_rd;
            rd_pend       <= rd_pend_next;
            sram_complete <= (state_next == IDLE) && !rd_pend_next;
            if (rd_rise) rd_idx_q <= ht_rd_idx;
        end
    end

    // Capture the winner's index and data at grant so later input changes are ignored.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cap_idx  <= '0;
            cap_data <= '0;
            cap_cb   <= 1'b0;
        end else if (gnt_tree) begin
            cap_cb <= 1'b0;
            if (wr_req) begin
                cap_idx  <= ht_node[70:64];
                cap_data <= ht_node[63:0];
            end else begin
                cap_idx <= rd_rise ? ht_rd_idx : rd_idx_q;
            end
        end else if (gnt_cb) begin
            cap_cb  <= 1'b1;
            cap_idx <= cb_idx;
        end
    end

    // Collect read words and deliver the result to the requesting stage.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_w0         <= '0;
            rd_w1         <= '0;
            nulls         <= '0;
            cb_node       <= '0;
            read_complete <= 1'b0;
            cb_ack        <= 1'b0;
        end else begin
            read_complete <= 1'b0;
            cb_ack        <= 1'b0;
            if (mem_ack && state == RD0) rd_w0 <= mem_rdata[IDX_W-1:0];
            if (mem_ack && state == RD1) rd_w1 <= mem_rdata;
            if (mem_ack && state == RD2) begin
                if (cap_cb) begin
                    cb_node <= {rd_w0, rd_w1, mem_rdata};
                    cb_ack  <= 1'b1;
                end else begin
                    nulls         <= {rd_w1, mem_rdata};
                    read_complete <= ht_ok;
                end
            end
        end
    end

    // Sticky write-done flag; a clear in the same cycle as a set wins.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            write_HT_fin <= 1'b0;
        end else if (ht_fin || !ht_ok) begin
            write_HT_fin <= 1'b0;
        end else if (state == WR2 && mem_ack) begin
            write_HT_fin <= 1'b1;
        end
    end

endmodule

// File: tb/tb_t05_ht_mem_ctrl.sv
// Scoreboard bench for t05_ht_mem_ctrl with a behavioural SRAM that acks after a programmable wait.
module tb_t05_ht_mem_ctrl;
    import t05_ht_pkg::*;

    localparam logic [31:0] BASE = 32'h3300_0000;

    logic              clk, rst_n;
    logic [3:0]        ht_en;
    logic              ht_pulse, ht_rd, ht_fin, cb_req, mem_ack;
    logic [NODE_W-1:0] ht_node;
    logic [IDX_W-1:0]  ht_rd_idx, cb_idx;
    logic [31:0]       mem_rdata;
    logic              mem_req, mem_we, write_HT_fin, read_complete, sram_complete, cb_ack;
    logic [31:0]       mem_addr, mem_wdata;
    logic [63:0]       nulls;
    logic [NODE_W-1:0] cb_node;

    t05_ht_mem_ctrl #(.NODE_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .ht_en(ht_en), .ht_pulse(ht_pulse), .ht_node(ht_node),
        .ht_rd(ht_rd), .ht_rd_idx(ht_rd_idx), .ht_fin(ht_fin), .cb_req(cb_req), .cb_idx(cb_idx),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .write_HT_fin(write_HT_fin),
        .read_complete(read_complete), .nulls(nulls), .sram_complete(sram_complete),
        .cb_ack(cb_ack), .cb_node(cb_node)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    beat_t             exp_beats[$];
    logic [63:0]       exp_nulls[$];
    logic [NODE_W-1:0] exp_cb[$];
    logic [31:0]       mem [logic [31:0]];

    int checks = 0, failures = 0;
    int rc_count = 0, cb_count = 0, beat_count = 0;
    int ack_delay = 0, wcnt = 0;
    logic [31:0] beat_addr, beat_wdata;
    beat_t       cur;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] waddr(input logic [6:0] idx, input int w);
        return BASE + 32'(idx) * 32'd12 + 32'(w * 4);
    endfunction

    task automatic push_write(input logic [6:0] idx, input logic [63:0] d);
        exp_beats.push_back('{1'b1, waddr(idx, 0), {25'b0, idx}});
        exp_beats.push_back('{1'b1, waddr(idx, 1), d[63:32]});
        exp_beats.push_back('{1'b1, waddr(idx, 2), d[31:0]});
    endtask

    task automatic push_read(input logic [6:0] idx);
        for (int w = 0; w < 3; w++) exp_beats.push_back('{1'b0, waddr(idx, w), 32'd0});
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2);
        mem[waddr(idx, 0)] = w0;
        mem[waddr(idx, 1)] = w1;
        mem[waddr(idx, 2)] = w2;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sram_complete && n < 200);
        if (!sram_complete) check(tag, 0, 1);
    endtask

    // SRAM model: acks after ack_delay waiting cycles, checks the beat against the scoreboard.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wcnt == 0) begin
                beat_addr  = mem_addr;
                beat_wdata = mem_wdata;
            end else begin
                check("addr_hold", mem_addr, beat_addr);
                check("wdata_hold", mem_wdata, beat_wdata);
            end
            if (wcnt >= ack_delay) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                beat_count++;
                if (mem_we) mem[mem_addr] = mem_wdata;
                else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
                if (exp_beats.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    cur = exp_beats.pop_front();
                    check("beat_we", mem_we, cur.we);
                    check("beat_addr", mem_addr, cur.addr);
                    if (cur.we) check("beat_wdata", mem_wdata, cur.wdata);
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Completion monitor: pops expected read results on each done pulse.
    always @(negedge clk) begin
        if (read_complete) begin
            rc_count++;
            if (exp_nulls.size() == 0) check("rc_unexpected", 1, 0);
            else check("nulls", nulls, exp_nulls.pop_front());
        end
        if (cb_ack) begin
            cb_count++;
            if (exp_cb.size() == 0) check("cb_unexpected", 1, 0);
            else check("cb_node", cb_node, exp_cb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k, r, s, rc0, cb0, b0;
        rst_n = 1'b1; ht_en = 4'd0; ht_pulse = 0; ht_rd = 0; ht_fin = 0; cb_req = 0;
        ht_node = '0; ht_rd_idx = '0; cb_idx = '0; mem_ack = 0; mem_rdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wr_fin", write_HT_fin, 0);
        check("rst_sram", sram_complete, 0);
        check("rst_nulls", nulls, 0);
        check("rst_cb_node", cb_node, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("idle_sram", sram_complete, 1);

        // Node write, index 5
        ht_en = 4'd3;
        push_write(7'd5, 64'h0123_4567_89AB_CDEF);
        ht_node = {7'd5, 64'h0123_4567_89AB_CDEF};
        ht_pulse = 1'b1;
        k = 0;
        while (!write_HT_fin && k < 50) begin
            @(negedge clk);
            k++;
            if (k == 1) ht_pulse = 1'b0;
        end
        check("wr_fin_latency", k, 4);
        @(negedge clk);
        check("wr_fin_sticky", write_HT_fin, 1);
        ht_fin = 1'b1;
        @(negedge clk);
        ht_fin = 1'b0;
        check("wr_fin_clear", write_HT_fin, 0);
        wait_idle("idle_t1");
        check("t1_beats_left", exp_beats.size(), 0);

        // Two-cycle tree read, index 3
        preload(7'd3, 32'd7, 32'hAAAA_0000, 32'h0000_BBBB);
        push_read(7'd3);
        exp_nulls.push_back(64'hAAAA_0000_0000_BBBB);
        rc0 = rc_count;
        ht_rd = 1'b1; ht_rd_idx = 7'd3;
        k = 0;
        while (!read_complete && k < 50) begin
            @(negedge clk);
            k++;
            if (k == 2) ht_rd = 1'b0;
        end
        check("rd_latency", k, 4);
        wait_idle("idle_t2");
        check("t2_rc_pulses", rc_count - rc0, 1);
        check("t2_beats_left", exp_beats.size(), 0);

        // Simultaneous write (idx 9) and read (idx 10): write first, read stays pending
        preload(7'd10, 32'd10, 32'h1234_5678, 32'h9ABC_DEF0);
        push_write(7'd9, 64'hDEAD_BEEF_CAFE_F00D);
        push_read(7'd10);
        exp_nulls.push_back(64'h1234_5678_9ABC_DEF0);
        ht_node = {7'd9, 64'hDEAD_BEEF_CAFE_F00D};
        ht_pulse = 1'b1; ht_rd = 1'b1; ht_rd_idx = 7'd10;
        k = 0; r = 0; s = 0;
        while (s == 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                ht_pulse = 1'b0;
                ht_rd = 1'b0;
            end
            if (read_complete) r = k;
            if (sram_complete) s = k;
        end
        check("t3_rd_done_cycle", r, 9);
        check("t3_sram_rise", s, r + 1);
        check("t3_wr_fin", write_HT_fin, 1);
        ht_fin = 1'b1;
        @(negedge clk);
        ht_fin = 1'b0;
        check("t3_beats_left", exp_beats.size(), 0);

        // Lone codebook read (idx 20) so the codebook was granted last
        preload(7'd20, 32'hABCD_00D5, 32'h1111_2222, 32'h3333_4444);
        push_read(7'd20);
        exp_cb.push_back({7'h55, 64'h1111_2222_3333_4444});
        cb0 = cb_count; rc0 = rc_count;
        cb_req = 1'b1; cb_idx = 7'd20;
        @(negedge clk);
        cb_req = 1'b0;
        wait_idle("idle_t4a");
        check("t4a_cb_pulses", cb_count - cb0, 1);

        // Tree and codebook held together: tree, cb, tree
        preload(7'd21, 32'h0000_0015, 32'h2222_3333, 32'h4444_5555);
        push_write(7'd22, 64'h0F0F_0F0F_F0F0_F0F0);
        push_read(7'd21);
        push_write(7'd22, 64'h0F0F_0F0F_F0F0_F0F0);
        exp_cb.push_back({7'h15, 64'h2222_3333_4444_5555});
        cb0 = cb_count;
        ht_fin = 1'b1;
        ht_node = {7'd22, 64'h0F0F_0F0F_F0F0_F0F0};
        ht_pulse = 1'b1; cb_req = 1'b1; cb_idx = 7'd21;
        repeat (12) @(negedge clk);
        ht_pulse = 1'b0; cb_req = 1'b0;
        wait_idle("idle_t4b");
        ht_fin = 1'b0;
        check("t4_beats_left", exp_beats.size(), 0);
        check("t4_cb_pulses", cb_count - cb0, 1);
        check("t4_rc_pulses", rc_count - rc0, 0);
        check("t4_wr_fin", write_HT_fin, 0);

        // Slow memory, reset asserted during WR1
        ack_delay = 3;
        exp_beats.push_back('{1'b1, waddr(7'd2, 0), 32'd2});
        b0 = beat_count;
        ht_node = {7'd2, 64'h1357_9BDF_2468_ACE0};
        ht_pulse = 1'b1;
        k = 0;
        while (beat_count == b0 && k < 50) begin
            @(negedge clk);
            k++;
            if (k == 1) ht_pulse = 1'b0;
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_wdata", mem_wdata, 0);
        check("rst_mid_nulls", nulls, 0);
        check("rst_mid_cb_node", cb_node, 0);
        check("rst_mid_sram", sram_complete, 0);
        check("t5_beats_left", exp_beats.size(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        check("t5_idle_after_rst", sram_complete, 1);

        // Write idx 6, then read it back while ht_en leaves 3 during RD1
        push_write(7'd6, 64'h0000_1111_2222_3333);
        ht_node = {7'd6, 64'h0000_1111_2222_3333};
        ht_pulse = 1'b1;
        @(negedge clk);
        ht_pulse = 1'b0;
        wait_idle("idle_t6a");
        check("t6_wr_fin_set", write_HT_fin, 1);
        push_read(7'd6);
        rc0 = rc_count;
        ht_rd = 1'b1; ht_rd_idx = 7'd6;
        @(negedge clk);
        ht_rd = 1'b0;
        @(negedge clk);
        ht_en = 4'd2;
        wait_idle("idle_t6b");
        check("t6_nulls", nulls, 64'h0000_1111_2222_3333);
        check("t6_rc_pulses", rc_count - rc0, 0);
        check("t6_wr_fin_clr", write_HT_fin, 0);
        check("t6_beats_left", exp_beats.size(), 0);
        check("end_nulls_left", exp_nulls.size(), 0);
        check("end_cb_left", exp_cb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
